demux8_stream: RTL and testbench

- Registered 1-to-8 stream demultiplexer with valid/ready handshaking.
- Each input word carries a 3-bit destination select. The word is steered into a one-entry holding slot for that output channel.
- Sits downstream of a single producer and fans out to eight independent consumers. It is the distributing counterpart of the team's 8:1 selection mux.

---
 rtl/demux8_pkg.sv | 20 ++
 rtl/demux8_stream_if.sv | 46 ++++
 rtl/demux8_slot.sv | 61 ++++++
 rtl/demux8_stream.sv | 86 ++++++++
 tb/tb_demux8_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux8_pkg.sv
// demux8_pkg -- shared types and constants for the demux8_stream block.
//   NUM_OUT      : number of output channels
//   SEL_W        : width of the destination select
//   CNT_W        : width of each per-channel drain counter (DEMUX8_COUNT_EN builds)
//   sel_t        : destination select type
//   slot_state_t : per-channel holding-slot state
package demux8_pkg;

    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 16;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux8_stream_if.sv
// demux8_stream_if -- producer-side and consumer-side stream signals of the
// 1-to-8 demultiplexer, bundled so the block and its environment share one view.
//   in_data   [N]         input word
//   in_sel    [SEL_W]     destination channel of in_data
//   in_valid              producer offers a word
//   in_ready              demux accepts the offered word this cycle
//   out_data  [NUM_OUT*N] channel k data at [k*N +: N]
//   out_valid [NUM_OUT]   channel k slot holds a word
//   out_ready [NUM_OUT]   consumer k takes its word this cycle
// modport master : environment (drives producer and consumer-ready signals)
// modport slave  : the demux itself
interface demux8_stream_if
    import demux8_pkg::*;
#(
    parameter int N = 32
);

    logic [N-1:0]         in_data;
    sel_t                 in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_OUT*N-1:0] out_data;
    logic [NUM_OUT-1:0]   out_valid;
    logic [NUM_OUT-1:0]   out_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/demux8_slot.sv
// demux8_slot -- one-entry holding register for a single output channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din this cycle (only asserted when the slot can take it)
//   drain      : consumer takes the held word this cycle
//   din  [N]   : word to capture
//   valid      : slot holds a word
//   dout [N]   : held word
// A load in the same cycle as a drain replaces the word with no empty cycle.
module demux8_slot
    import demux8_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic [N-1:0] din,
    output logic         valid,
    output logic [N-1:0] dout
);

    slot_state_t  state_q, state_d;
    logic [N-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                    data_d  = din;
                end
            end
            FULL: begin
                if (load) begin
                    // Drain and load together: keep FULL, swap in the new word.
                    data_d = din;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign valid = (state_q == FULL);
    assign dout  = data_q;

endmodule

// File: rtl/demux8_stream.sv
// demux8_stream -- registered 1-to-8 stream demultiplexer with valid/ready.
// Each input word is steered by in_sel into that channel's one-entry slot and
// appears on the channel output one cycle after acceptance.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset (clears all slots, in_ready low)
//   bus       : demux8_stream_if.slave (in_* producer side, out_* consumers)
// Optional build macro DEMUX8_COUNT_EN adds per-channel drain counters:
//   cnt_clear : clear all counters on the next edge (wins over a drain)
//   cnt       : counter k at [k*CNT_W +: CNT_W], wraps at all-ones
module demux8_stream
    import demux8_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    demux8_stream_if.slave           bus
`ifdef DEMUX8_COUNT_EN
    ,
    input  logic                     cnt_clear,
    output logic [NUM_OUT*CNT_W-1:0] cnt
`endif
);

    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] drain;
    logic [NUM_OUT-1:0] slot_valid;
    logic               in_ready;

    // Readiness depends only on the addressed slot, so a stalled channel never
    // blocks words bound for other channels.
    assign in_ready = rst_n & (~slot_valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
    assign bus.in_ready = in_ready;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign load[k]  = bus.in_valid & in_ready & (bus.in_sel == sel_t'(k));
        assign drain[k] = slot_valid[k] & bus.out_ready[k];

        demux8_slot #(
            .N (N)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .drain (drain[k]),
            .din   (bus.in_data),
            .valid (slot_valid[k]),
            .dout  (bus.out_data[k*N +: N])
        );
    end

    assign bus.out_valid = slot_valid;

`ifdef DEMUX8_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_OUT];
    logic [CNT_W-1:0] cnt_d [NUM_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clear) begin
                cnt_d[k] = '0;
            end else if (drain[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        assign cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_demux8_stream.sv
module tb_demux8_stream;
    import demux8_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    demux8_stream_if #(.N(N)) bus ();

`ifdef DEMUX8_COUNT_EN
    logic                     cnt_clear = 1'b0;
    logic [NUM_OUT*CNT_W-1:0] cnt;
`endif

    demux8_stream #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX8_COUNT_EN
        ,
        .cnt_clear (cnt_clear),
        .cnt       (cnt)
`endif
    );

    always #5 clk = ~clk;

    // Producer must hold a stalled word unchanged until it is accepted.
    logic         hold_prev = 1'b0;
    logic [N-1:0] data_prev;
    sel_t         sel_prev;
    always @(posedge clk) begin
        if (hold_prev && rst_n) begin
            checks++;
            if (!bus.in_valid || bus.in_data !== data_prev || bus.in_sel !== sel_prev) begin
                errors++;
                $display("FAIL axi_hold: valid=%0b data=%h sel=%0d required data=%h sel=%0d",
                         bus.in_valid, bus.in_data, bus.in_sel, data_prev, sel_prev);
            end
        end
        hold_prev = rst_n && bus.in_valid && !bus.in_ready;
        data_prev = bus.in_data;
        sel_prev  = bus.in_sel;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.out_valid !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_valid: got %h required 00", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b required 0", bus.in_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL idle_outputs: valid=%h data=%h required 00 / 0", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b required 1", bus.in_ready);
        end
        step();
    endtask

    task automatic test_single_word();
        bus.in_data  = 32'hDEADBEEF;
        bus.in_sel   = 3'd5;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: got %b required 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        checks++;
        if (bus.out_valid !== 8'b0010_0000 || bus.out_data[5*N +: N] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_deliver: valid=%b data=%h required 00100000 / deadbeef",
                     bus.out_valid, bus.out_data[5*N +: N]);
        end
        step();
        checks++;
        if (bus.out_valid !== 8'b0010_0000 || bus.out_data[5*N +: N] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_hold: valid=%b data=%h required 00100000 / deadbeef",
                     bus.out_valid, bus.out_data[5*N +: N]);
        end
        bus.out_ready = 8'b0010_0000;
        step();
        bus.out_ready = '0;
        checks++;
        if (bus.out_valid !== 8'h00) begin
            errors++;
            $display("FAIL single_drain: valid=%b required 00000000", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.in_data  = 32'h2A;
        bus.in_sel   = 3'd2;
        bus.in_valid = 1'b1;
        step();
        bus.in_data = 32'h22;
        #1;
        checks++;
        if (bus.out_valid !== 8'b0000_0100 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_blocked: valid=%b in_ready=%b required 00000100 / 0",
                     bus.out_valid, bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_data[2*N +: N] !== 32'h2A || bus.out_valid !== 8'b0000_0100) begin
            errors++;
            $display("FAIL bp_stable: data=%h valid=%b required 0000002a / 00000100",
                     bus.out_data[2*N +: N], bus.out_valid);
        end
        bus.out_ready = 8'b0000_0100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_on_drain: got %b required 1", bus.in_ready);
        end
        step();
        bus.out_ready = '0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 8'b0000_0100 || bus.out_data[2*N +: N] !== 32'h22) begin
            errors++;
            $display("FAIL bp_drain_load: valid=%b data=%h required 00000100 / 00000022",
                     bus.out_valid, bus.out_data[2*N +: N]);
        end
        bus.in_data  = 32'h99;
        bus.in_sel   = 3'd2;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_blocked2: got %b required 0", bus.in_ready);
        end
        bus.in_data = 32'h3;
        bus.in_sel  = 3'd3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready: got %b required 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 8'b0000_1100 || bus.out_data[3*N +: N] !== 32'h3 ||
            bus.out_data[2*N +: N] !== 32'h22) begin
            errors++;
            $display("FAIL bp_other_deliver: valid=%b ch3=%h ch2=%h required 00001100 / 3 / 22",
                     bus.out_valid, bus.out_data[3*N +: N], bus.out_data[2*N +: N]);
        end
        bus.out_ready = 8'b0000_1100;
        step();
        bus.out_ready = '0;
        checks++;
        if (bus.out_valid !== 8'h00) begin
            errors++;
            $display("FAIL bp_drain_all: valid=%b required 00000000", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 8'b1000_0000;
        for (int i = 0; i < 16; i++) begin
            bus.in_data  = 32'(i);
            bus.in_sel   = 3'd7;
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %b required 1", i, bus.in_ready);
            end
            step();
            checks++;
            if (bus.out_valid !== 8'b1000_0000 || bus.out_data[7*N +: N] !== 32'(i)) begin
                errors++;
                $display("FAIL stream_word[%0d]: valid=%b data=%h required 10000000 / %h",
                         i, bus.out_valid, bus.out_data[7*N +: N], 32'(i));
            end
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = '0;
        checks++;
        if (bus.out_valid !== 8'h00) begin
            errors++;
            $display("FAIL stream_empty: valid=%b required 00000000", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_sel = 3'd0; bus.in_data = 32'hA0; step();
        bus.in_sel = 3'd4; bus.in_data = 32'hA4; step();
        bus.in_sel = 3'd6; bus.in_data = 32'hA6; step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 8'b0101_0001) begin
            errors++;
            $display("FAIL rstmid_fill: valid=%b required 01010001", bus.out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b in_ready=%b data_nonzero=%b required 0 / 0 / 0",
                     bus.out_valid, bus.in_ready, (bus.out_data != '0));
        end
        #1;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 8'h00 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_no_replay: valid=%b data_nonzero=%b required 0 / 0",
                     bus.out_valid, (bus.out_data != '0));
        end
    endtask

`ifdef DEMUX8_COUNT_EN
    task automatic test_counters();
        checks++;
        if (cnt !== '0) begin
            errors++;
            $display("FAIL cnt_reset: nonzero counters, cnt0=%0d cnt1=%0d required 0",
                     cnt[0 +: 16], cnt[16 +: 16]);
        end
        bus.out_ready = 8'b0000_0010;
        bus.in_sel    = 3'd1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = 32'(100 + i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid  = 1'b0;
        step();
        bus.out_ready = 8'b0000_0001;
        bus.in_sel    = 3'd0;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        step();
        bus.out_ready = '0;
        checks++;
        if (cnt[16 +: 16] !== 16'd3 || cnt[0 +: 16] !== 16'd1) begin
            errors++;
            $display("FAIL cnt_drains: cnt1=%0d cnt0=%0d required 3 / 1", cnt[16 +: 16], cnt[0 +: 16]);
        end
        bus.in_sel   = 3'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'b0000_0010;
        cnt_clear     = 1'b1;
        step();
        cnt_clear     = 1'b0;
        bus.out_ready = '0;
        checks++;
        if (cnt[16 +: 16] !== 16'd0 || bus.out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL cnt_clear_prio: cnt1=%0d valid1=%b required 0 / 0",
                     cnt[16 +: 16], bus.out_valid[1]);
        end
        bus.out_ready = 8'b0000_0001;
        bus.in_sel    = 3'd0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.in_data = 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (cnt[0 +: 16] !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_preload: cnt0=%h required ffff", cnt[0 +: 16]);
        end
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = '0;
        checks++;
        if (cnt[0 +: 16] !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_wrap: cnt0=%h required 0000", cnt[0 +: 16]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef DEMUX8_COUNT_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
